// File: rtl/hdmi_timing_gen_pkg.sv
// Shared types and mode constants for the parametrised HDMI video timing generator.
// Mode constants list each timing set as {active, front porch, sync, back porch}.
package hdmi_timing_gen_pkg;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic sof;
      logic eol;
   } timing_t;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_mode_t;

   localparam axis_mode_t VGA_640x480_H   = '{640, 16, 96, 48};
   localparam axis_mode_t VGA_640x480_V   = '{480, 10, 2, 33};
   localparam axis_mode_t HD_1280x720_H   = '{1280, 110, 40, 220};
   localparam axis_mode_t HD_1280x720_V   = '{720, 5, 5, 20};
   localparam axis_mode_t FHD_1920x1080_H = '{1920, 88, 44, 148};
   localparam axis_mode_t FHD_1920x1080_V = '{1080, 4, 5, 36};

   function automatic int unsigned timingTotal(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/hdmi_timing_gen_delay.sv
// En-gated shift register used to align the timing outputs with a downstream pixel pipeline.
// DEPTH = 0 collapses to a plain wire.
module timing_delay_line #(
   parameter int               WIDTH   = 5,
   parameter int               DEPTH   = 0,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unusedSigs;
         assign unusedSigs = ^{clk, rst, en};
         assign dout = din;
      end else begin : g_regs
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else if (en) begin
               stage_q[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
         end

         assign dout = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: h/v counters, sync/de/marker decode, one output register
// with polarity applied, then an optional alignment delay line.
module hdmi_timing_gen
   import hdmi_timing_gen_pkg::*;
#(
   parameter int H_ACTIVE  = 1280,
   parameter int H_FP      = 110,
   parameter int H_SYNC    = 40,
   parameter int H_BP      = 220,
   parameter int V_ACTIVE  = 720,
   parameter int V_FP      = 5,
   parameter int V_SYNC    = 5,
   parameter int V_BP      = 20,
   parameter int HS_POL    = 1,
   parameter int VS_POL    = 1,
   parameter int OUT_DELAY = 0,
   localparam int H_TOTAL  = int'(timingTotal(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   localparam int V_TOTAL  = int'(timingTotal(V_ACTIVE, V_FP, V_SYNC, V_BP)),
   localparam int HW       = $clog2(H_TOTAL),
   localparam int VW       = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          sof,
   output logic          eol
);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic          HS_IDLE  = (HS_POL == 0);
   localparam logic          VS_IDLE  = (VS_POL == 0);
   localparam timing_t       RST_VAL  = '{hs: HS_IDLE, vs: VS_IDLE, de: 1'b0, sof: 1'b0, eol: 1'b0};

   generate
      if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
          V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_badTiming
         $error("hdmi_timing_gen: every active/porch/sync parameter must be >= 1");
      end
      if (OUT_DELAY < 0 || OUT_DELAY > 15) begin : g_badDelay
         $error("hdmi_timing_gen: OUT_DELAY must be in 0..15");
      end
   endgenerate

   logic [HW-1:0] hCnt_q, hCnt_d;
   logic [VW-1:0] vCnt_q, vCnt_d;
   timing_t       raw;
   timing_t       out_q, out_d;
   timing_t       delayed;

   // v_cnt steps on the same edge that wraps h_cnt, so vsync edges land on h == 0.
   always_comb begin
      hCnt_d = hCnt_q;
      vCnt_d = vCnt_q;
      if (en) begin
         if (hCnt_q == H_LAST) begin
            hCnt_d = '0;
            vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
         end else begin
            hCnt_d = hCnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      raw.hs  = (hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST);
      raw.vs  = (vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST);
      raw.de  = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
      raw.sof = (hCnt_q == '0) && (vCnt_q == '0);
      raw.eol = (hCnt_q == H_EOL) && (vCnt_q < V_ACT);
      out_d     = raw;
      out_d.hs  = raw.hs ^ HS_IDLE;
      out_d.vs  = raw.vs ^ VS_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
         out_q  <= RST_VAL;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
         if (en) out_q <= out_d;
      end
   end

   timing_delay_line #(
      .WIDTH  (5),
      .DEPTH  (OUT_DELAY),
      .RST_VAL(RST_VAL)
   ) u_delay (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .din (out_q),
      .dout(delayed)
   );

   assign h_cnt = hCnt_q;
   assign v_cnt = vCnt_q;
   assign hsync = delayed.hs;
   assign vsync = delayed.vs;
   assign de    = delayed.de;
   assign sof   = delayed.sof;
   assign eol   = delayed.eol;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen in the small 16x8 mode: three instances (active-high, active-low,
// OUT_DELAY=5) checked against a reference counter model plus a table of first-frame events.
module tb_hdmi_timing_gen;

   localparam int HW = 4;
   localparam int VW = 3;

   typedef logic [4:0] outs_t;

   typedef struct {
      int    cyc;
      outs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;

   logic [HW-1:0] hA, hN, hD;
   logic [VW-1:0] vA, vN, vD;
   logic hsA, vsA, deA, sofA, eolA;
   logic hsN, vsN, deN, sofN, eolN;
   logic hsD, vsD, deD, sofD, eolD;

   int checks   = 0;
   int failures = 0;

   int    mH = 0;
   int    mV = 0;
   outs_t q0[$];
   outs_t q5[$];
   outs_t exp0 = 5'b00000;
   outs_t exp5 = 5'b00000;
   vec_t  vecs[16];

   always #5 clk = ~clk;

   hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1), .VS_POL(1), .OUT_DELAY(0)) dutA (
      .clk(clk), .rst(rst), .en(en), .h_cnt(hA), .v_cnt(vA),
      .hsync(hsA), .vsync(vsA), .de(deA), .sof(sofA), .eol(eolA));

   hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .OUT_DELAY(0)) dutN (
      .clk(clk), .rst(rst), .en(en), .h_cnt(hN), .v_cnt(vN),
      .hsync(hsN), .vsync(vsN), .de(deN), .sof(sofN), .eol(eolN));

   hdmi_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1), .VS_POL(1), .OUT_DELAY(5)) dutD (
      .clk(clk), .rst(rst), .en(en), .h_cnt(hD), .v_cnt(vD),
      .hsync(hsD), .vsync(vsD), .de(deD), .sof(sofD), .eol(eolD));

   // Reference decode, ordered {hs, vs, de, sof, eol}, written straight from the small-mode windows.
   function automatic outs_t rawOf(input int h, input int v);
      outs_t r;
      r[4] = (h >= 10) && (h <= 12);
      r[3] = (v >= 5) && (v <= 6);
      r[2] = (h < 8) && (v < 4);
      r[1] = (h == 0) && (v == 0);
      r[0] = (h == 7) && (v < 4);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mH = 0;
      mV = 0;
      q0.delete();
      q5.delete();
      for (int i = 0; i < 5; i++) q5.push_back(5'b00000);
      exp0 = 5'b00000;
      exp5 = 5'b00000;
   endtask

   // Scoreboard compare of every instance against the model after one clock.
   task automatic checkAll();
      checkOutput("outs_pos", {hsA, vsA, deA, sofA, eolA}, exp0);
      checkOutput("outs_neg", {hsN, vsN, deN, sofN, eolN}, exp0 ^ 5'b11000);
      checkOutput("outs_dly", {hsD, vsD, deD, sofD, eolD}, exp5);
      checkOutput("cnt_pos", {hA, vA}, {4'(mH), 3'(mV)});
      checkOutput("cnt_neg", {hN, vN}, {4'(mH), 3'(mV)});
      checkOutput("cnt_dly", {hD, vD}, {4'(mH), 3'(mV)});
   endtask

   task automatic applyStimulus();
      outs_t r;
      @(posedge clk);
      #1;
      if (en) begin
         r = rawOf(mH, mV);
         q0.push_back(r);
         q5.push_back(r);
         exp0 = q0.pop_front();
         exp5 = q5.pop_front();
         if (mH == 15) begin
            mH = 0;
            mV = (mV == 7) ? 0 : mV + 1;
         end else begin
            mH = mH + 1;
         end
      end
      checkAll();
   endtask

   task automatic runTable();
      for (int cyc = 1; cyc <= 135; cyc++) begin
         applyStimulus();
         foreach (vecs[i]) begin
            if (vecs[i].cyc == cyc) begin
               checkOutput($sformatf("tbl_pos_c%0d", cyc), {hsA, vsA, deA, sofA, eolA}, vecs[i].exp);
               checkOutput($sformatf("tbl_neg_c%0d", cyc), {hsN, vsN, deN, sofN, eolN},
                           vecs[i].exp ^ 5'b11000);
            end
            if (vecs[i].cyc + 5 == cyc)
               checkOutput($sformatf("tbl_dly_c%0d", cyc), {hsD, vsD, deD, sofD, eolD}, vecs[i].exp);
         end
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_pos"}, {hsA, vsA, deA, sofA, eolA, hA, vA}, 12'h000);
      checkOutput({tag, "_neg"}, {hsN, vsN, deN, sofN, eolN, hN, vN}, {5'b11000, 7'h00});
      checkOutput({tag, "_dly"}, {hsD, vsD, deD, sofD, eolD, hD, vD}, 12'h000);
   endtask

   initial begin
      bit found;
      vecs[0]  = '{1,   5'b00110};
      vecs[1]  = '{2,   5'b00100};
      vecs[2]  = '{8,   5'b00101};
      vecs[3]  = '{9,   5'b00000};
      vecs[4]  = '{11,  5'b10000};
      vecs[5]  = '{13,  5'b10000};
      vecs[6]  = '{14,  5'b00000};
      vecs[7]  = '{17,  5'b00100};
      vecs[8]  = '{27,  5'b10000};
      vecs[9]  = '{56,  5'b00101};
      vecs[10] = '{72,  5'b00000};
      vecs[11] = '{80,  5'b00000};
      vecs[12] = '{81,  5'b01000};
      vecs[13] = '{91,  5'b11000};
      vecs[14] = '{113, 5'b00000};
      vecs[15] = '{129, 5'b00110};

      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      @(negedge clk);
      rst = 1'b0;
      runTable();

      // Pseudo-random enable gaps: the scoreboard only advances on enabled edges.
      for (int i = 0; i < 1000; i++) begin
         en = 1'($urandom_range(0, 1));
         applyStimulus();
      end
      en = 1'b1;

      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         applyStimulus();
         if (mH == 5 && mV == 6) found = 1'b1;
      end
      checkOutput("reach_h5_v6", {31'd0, found}, 32'd1);

      #2;
      rst = 1'b1;
      #1;
      checkResetState("async_rst");
      modelReset();
      @(posedge clk);
      #1;
      checkResetState("rst_held");
      @(negedge clk);
      rst = 1'b0;
      runTable();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
